i2s_slv_frontend: RTL

//  Slave-mode input front end for the I2S controller. Synchronises external sck/ws/sd into

---
 rtl/i2s_slv_frontend.sv | 324 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2s_slv_frontend.sv
// -----------------------------------------------------------------------------
// i2s_slv_frontend
// Slave-mode input front end for the I2S controller. The external sck/ws/sd pins
// are synchronised into pclk. The block makes a one-cycle sample strobe for each
// active sck edge and hands the sampled ws/sd bits to the core. It also measures
// the frame length and tracks lock and sck-idle timeout, so firmware can see a
// master that is dead or unstable.
//
// Optional feature (compile-time macro I2S_SLV_GLITCH_FILT_EN):
//   A 3-sample majority filter is placed on the synchronised sck. Single-cycle
//   sck glitches are suppressed, and ws/sd get two extra delay stages so that
//   they stay aligned with the filtered sck. Pin-to-strobe latency is
//   SYNC_STAGES+3 with the filter and SYNC_STAGES+1 without it.
//
// Ports:
//   clk_i        pclk
//   rst_n_i      asynchronous reset, active low
//   en_i         block enable; when low, everything except err_o is cleared
//   pol_i        0: sample on sck rise, 1: sample on sck fall
//   clr_i        clears err_o (a set in the same cycle wins)
//   tout_i       sck-idle timeout in clk cycles, 0 disables the timeout
//   sck_i/ws_i/sd_i  raw external pins
//   sck_o        synchronised sck level
//   smp_o        sample strobe, one cycle per active sck edge
//   ws_o/sd_o    ws/sd captured at the last strobe
//   ws_edge_o    pulse coincident with smp_o when the captured ws changes
//   frame_len_o  number of bits in the last complete frame
//   lock_o       two consecutive frames of equal length, no timeout since
//   err_o        sticky: length mismatch while locked, or bit counter saturation
//   tout_o       high while sck has been idle for >= tout_i cycles
// -----------------------------------------------------------------------------
module i2s_slv_frontend #(
  parameter int SYNC_STAGES = 2,
  parameter int LEN_WIDTH   = 8,
  parameter int TOUT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic                  pol_i,
  input  logic                  clr_i,
  input  logic [TOUT_WIDTH-1:0] tout_i,
  input  logic                  sck_i,
  input  logic                  ws_i,
  input  logic                  sd_i,
  output logic                  sck_o,
  output logic                  smp_o,
  output logic                  ws_o,
  output logic                  sd_o,
  output logic                  ws_edge_o,
  output logic [LEN_WIDTH-1:0]  frame_len_o,
  output logic                  lock_o,
  output logic                  err_o,
  output logic                  tout_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_MEAS   = 2'd2,
    ST_LOCKED = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] ws_sync_q;
  logic [SYNC_STAGES-1:0] sd_sync_q;
  logic                   sck_lvl_s;
  logic                   ws_lvl_s;
  logic                   sd_lvl_s;
  logic                   sck_prev_q;

  logic                   smp_q;
  logic                   ws_q;
  logic                   sd_q;
  logic                   ws_edge_q;

  logic [TOUT_WIDTH-1:0]  idle_cnt_q;
  logic [TOUT_WIDTH-1:0]  idle_cnt_d;
  logic                   tout_q;
  logic                   tout_d;

  state_e                 state_q;
  state_e                 state_d;
  logic [LEN_WIDTH-1:0]   bit_cnt_q;
  logic [LEN_WIDTH-1:0]   bit_cnt_d;
  logic [LEN_WIDTH-1:0]   frame_len_q;
  logic [LEN_WIDTH-1:0]   frame_len_d;
  logic                   lock_q;
  logic                   err_q;

  logic                   rise_s;
  logic                   fall_s;
  logic                   any_edge_s;
  logic                   smp_s;
  logic                   frame_start_s;
  logic                   bit_max_s;
  logic [LEN_WIDTH-1:0]   len_new_s;
  logic                   sat_s;
  logic                   mismatch_s;
  logic                   tout_rise_s;
  logic                   err_set_s;

  // Pin synchronisers; all three chains have the same depth, so ws and sd are not skewed against sck.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sck_sync_q <= '0;
      ws_sync_q  <= '0;
      sd_sync_q  <= '0;
    end else if (!en_i) begin
      sck_sync_q <= '0;
      ws_sync_q  <= '0;
      sd_sync_q  <= '0;
    end else begin
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
      ws_sync_q  <= {ws_sync_q[SYNC_STAGES-2:0], ws_i};
      sd_sync_q  <= {sd_sync_q[SYNC_STAGES-2:0], sd_i};
    end
  end

`ifdef I2S_SLV_GLITCH_FILT_EN
  logic [1:0] sck_hist_q;
  logic       sck_filt_q;
  logic [1:0] ws_dly_q;
  logic [1:0] sd_dly_q;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Majority filter on sync sck; ws/sd are delayed by two stages to match its latency.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sck_hist_q <= 2'b00;
      sck_filt_q <= 1'b0;
      ws_dly_q   <= 2'b00;
      sd_dly_q   <= 2'b00;
    end else if (!en_i) begin
      sck_hist_q <= 2'b00;
      sck_filt_q <= 1'b0;
      ws_dly_q   <= 2'b00;
      sd_dly_q   <= 2'b00;
    end else begin
      sck_hist_q <= {sck_hist_q[0], sck_sync_q[SYNC_STAGES-1]};
      sck_filt_q <= maj3(sck_sync_q[SYNC_STAGES-1], sck_hist_q[0], sck_hist_q[1]);
      ws_dly_q   <= {ws_dly_q[0], ws_sync_q[SYNC_STAGES-1]};
      sd_dly_q   <= {sd_dly_q[0], sd_sync_q[SYNC_STAGES-1]};
    end
  end

  assign sck_lvl_s = sck_filt_q;
  assign ws_lvl_s  = ws_dly_q[1];
  assign sd_lvl_s  = sd_dly_q[1];
`else
  assign sck_lvl_s = sck_sync_q[SYNC_STAGES-1];
  assign ws_lvl_s  = ws_sync_q[SYNC_STAGES-1];
  assign sd_lvl_s  = sd_sync_q[SYNC_STAGES-1];
`endif

  // Extra flop that holds the previous sck level for edge detection.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sck_prev_q <= 1'b0;
    end else if (!en_i) begin
      sck_prev_q <= 1'b0;
    end else begin
      sck_prev_q <= sck_lvl_s;
    end
  end

  assign rise_s        = sck_lvl_s & ~sck_prev_q;
  assign fall_s        = ~sck_lvl_s & sck_prev_q;
  assign any_edge_s    = sck_lvl_s ^ sck_prev_q;
  assign smp_s         = en_i & (pol_i ? fall_s : rise_s);
  // A frame starts when the sampled ws goes from 1 to 0.
  assign frame_start_s = smp_s & ws_q & ~ws_lvl_s;

  // Strobe and captured ws/sd; ws_edge is compared against the previously captured ws.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      smp_q     <= 1'b0;
      ws_q      <= 1'b0;
      sd_q      <= 1'b0;
      ws_edge_q <= 1'b0;
    end else if (!en_i) begin
      smp_q     <= 1'b0;
      ws_q      <= 1'b0;
      sd_q      <= 1'b0;
      ws_edge_q <= 1'b0;
    end else if (smp_s) begin
      smp_q     <= 1'b1;
      ws_q      <= ws_lvl_s;
      sd_q      <= sd_lvl_s;
      ws_edge_q <= ws_lvl_s ^ ws_q;
    end else begin
      smp_q     <= 1'b0;
      ws_q      <= ws_q;
      sd_q      <= sd_q;
      ws_edge_q <= 1'b0;
    end
  end

  // idle_cnt holds the number of cycles since the last sync sck edge. It saturates at its maximum.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (any_edge_s) begin
      idle_cnt_d = {{(TOUT_WIDTH-1){1'b0}}, 1'b1};
    end else if (&idle_cnt_q) begin
      idle_cnt_d = idle_cnt_q;
    end else begin
      idle_cnt_d = idle_cnt_q + {{(TOUT_WIDTH-1){1'b0}}, 1'b1};
    end
    tout_d = (tout_i != {TOUT_WIDTH{1'b0}}) && !any_edge_s && (idle_cnt_d >= tout_i);
  end

  assign tout_rise_s = tout_d & ~tout_q;

  // Idle counter and timeout flag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idle_cnt_q <= '0;
      tout_q     <= 1'b0;
    end else if (!en_i) begin
      idle_cnt_q <= '0;
      tout_q     <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      tout_q     <= tout_d;
    end
  end

  assign bit_max_s  = &bit_cnt_q;
  // The length includes the start bit of the frame being closed. It sticks at the maximum.
  assign len_new_s  = bit_max_s ? bit_cnt_q : (bit_cnt_q + LEN_WIDTH'(1));
  assign sat_s      = smp_s & ~frame_start_s & bit_max_s;
  assign mismatch_s = frame_start_s & (state_q == ST_LOCKED) & (len_new_s != frame_len_q);
  assign err_set_s  = en_i & (mismatch_s | sat_s);

  // Frame tracker next state: bit counter, latched length, lock FSM.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    frame_len_d = frame_len_q;
    if (frame_start_s) begin
      bit_cnt_d = '0;
    end else if (smp_s && !bit_max_s) begin
      bit_cnt_d = bit_cnt_q + LEN_WIDTH'(1);
    end else begin
      bit_cnt_d = bit_cnt_q;
    end
    if (tout_rise_s) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
    end else if (frame_start_s) begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SYNC;
        end
        ST_SYNC: begin
          frame_len_d = len_new_s;
          state_d     = ST_MEAS;
        end
        ST_MEAS: begin
          frame_len_d = len_new_s;
          state_d     = (len_new_s == frame_len_q) ? ST_LOCKED : ST_MEAS;
        end
        ST_LOCKED: begin
          frame_len_d = len_new_s;
          state_d     = (len_new_s == frame_len_q) ? ST_LOCKED : ST_MEAS;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if (sat_s && (state_q == ST_LOCKED)) begin
      state_d = ST_MEAS;
    end else begin
      state_d = state_q;
    end
  end

  // Frame tracker registers; lock_o is registered from the next state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      frame_len_q <= '0;
      lock_q      <= 1'b0;
    end else if (!en_i) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      frame_len_q <= '0;
      lock_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_len_q <= frame_len_d;
      lock_q      <= (state_d == ST_LOCKED);
    end
  end

  // Sticky error flag. It survives en_i=0, and a set wins over clr_i.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_q <= 1'b0;
    end else if (err_set_s) begin
      err_q <= 1'b1;
    end else if (clr_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q;
    end
  end

  assign sck_o       = sck_lvl_s;
  assign smp_o       = smp_q;
  assign ws_o        = ws_q;
  assign sd_o        = sd_q;
  assign ws_edge_o   = ws_edge_q;
  assign frame_len_o = frame_len_q;
  assign lock_o      = lock_q;
  assign err_o       = err_q;
  assign tout_o      = tout_q;

endmodule
